// File: rtl/xor86_sched.sv
// xor86_sched: round-robin sequencer sharing one external 74x86 quad-XOR
// across NREQ requesters. Each DW-bit job is streamed LSB nibble first.
// Optional feature macro: XOR86_SCHED_PARITY_EN adds the resp_par output.
module xor86_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 16,
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [3:0]       xor_a,
  output logic [3:0]       xor_b,
  input  logic [3:0]       xor_y,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IW-1:0]    resp_id,
  output logic [DW-1:0]    resp_y,
  output logic             busy
`ifdef XOR86_SCHED_PARITY_EN
  ,
  output logic             resp_par
`endif
);

  localparam int unsigned NIB = DW / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;

  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   scan_idx;
  logic [NREQ-1:0] scan_vec;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [DW-1:0]   nib_mask;
  logic [DW-1:0]   nib_data;

  // Rotating priority search starting just after the last granted requester
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    scan_vec  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((32'(ptr) + k) % NREQ);
      scan_vec = req_valid >> scan_idx;
      if (!grant_vld && scan_vec[0]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Accept strobe is only offered while idle, one-hot on the winner
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  // Winner's operands, extracted by shift to keep selects width-exact
  always_comb begin
    sel_a = DW'(req_a >> (32'(grant_idx) * DW));
    sel_b = DW'(req_b >> (32'(grant_idx) * DW));
  end

  // Current nibble towards the 74x86; parked at zero when not streaming
  always_comb begin
    xor_a = 4'h0;
    xor_b = 4'h0;
    if (state == RUN) begin
      xor_a = 4'(a_q >> (32'(cnt) * 4));
      xor_b = 4'(b_q >> (32'(cnt) * 4));
    end
  end

  // Merge the returned nibble into its slot of the result
  always_comb begin
    nib_mask = DW'(4'hF) << (32'(cnt) * 4);
    nib_data = DW'(xor_y) << (32'(cnt) * 4);
  end

  // Sequencer state, job latch and result assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= IW'(NREQ - 1);
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      resp_y  <= '0;
      resp_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            resp_id <= grant_idx;
            ptr     <= grant_idx;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          resp_y <= (resp_y & ~nib_mask) | nib_data;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(NIB - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decoded straight from the state register
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

`ifdef XOR86_SCHED_PARITY_EN
  // Parity tracks resp_y, so it is valid whenever resp_valid is
  assign resp_par = ^resp_y;
`endif

endmodule

// File: tb/tb_xor86_sched.sv
// Directed bench for xor86_sched with a transaction-level reference model.
module tb_xor86_sched;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int IW   = 2;
  localparam int NIB  = DW / 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [3:0]        xor_a;
  logic [3:0]        xor_b;
  logic [3:0]        xor_y;
  logic              resp_valid;
  logic              resp_ready;
  logic [IW-1:0]     resp_id;
  logic [DW-1:0]     resp_y;
  logic              busy;
`ifdef XOR86_SCHED_PARITY_EN
  logic              resp_par;
`endif

  logic [DW-1:0] opa [NREQ];
  logic [DW-1:0] opb [NREQ];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_a[gi*DW +: DW] = opa[gi];
    assign req_b[gi*DW +: DW] = opb[gi];
  end

  // The external 74x86 package
  assign xor_y = xor_a ^ xor_b;

  xor86_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .xor_a      (xor_a),
    .xor_b      (xor_b),
    .xor_y      (xor_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .busy       (busy)
`ifdef XOR86_SCHED_PARITY_EN
    ,
    .resp_par   (resp_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_busy;
  int            m_age;   // 1..NIB streaming nibble age, NIB+1 = result held
  int            m_ptr;
  logic [DW-1:0] m_a, m_b, m_y;
  logic [IW-1:0] m_rid;

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int i = (p + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
      m_ptr  <= NREQ - 1;
      m_y    <= '0;
      m_rid  <= '0;
    end else if (!m_busy) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_busy <= 1'b1;
        m_age  <= 1;
        m_ptr  <= g;
        m_rid  <= IW'(g);
        m_a    <= opa[g];
        m_b    <= opb[g];
      end
    end else if (m_age <= NIB) begin
      if (m_age == NIB) m_y <= m_a ^ m_b;
      m_age <= m_age + 1;
    end else if (resp_ready) begin
      m_busy <= 1'b0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      bit run;
      bit done;
      int g;
      logic [NREQ-1:0] err;
      logic [3:0] ea, eb;
      run  = m_busy && (m_age <= NIB);
      done = m_busy && (m_age == NIB + 1);
      err  = '0;
      if (!m_busy) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) err = NREQ'(1) << g;
      end
      ea = run ? 4'(m_a >> (4 * (m_age - 1))) : 4'h0;
      eb = run ? 4'(m_b >> (4 * (m_age - 1))) : 4'h0;
      chk("m_busy", busy, m_busy);
      chk("m_resp_valid", resp_valid, done);
      chk("m_req_ready", req_ready, err);
      chk("m_xor_a", xor_a, ea);
      chk("m_xor_b", xor_b, eb);
      chk("m_resp_id", resp_id, m_rid);
      if (!run) begin
        chk("m_resp_y", resp_y, m_y);
`ifdef XOR86_SCHED_PARITY_EN
        chk("m_resp_par", resp_par, ^m_y);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic wait_grant(input logic [IW-1:0] id, output bit ok);
    int n = 0;
    ok = 0;
    while (n < 30) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1;
        break;
      end
      n++;
    end
    if (!ok) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_job(input logic [IW-1:0] id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int hold, output logic [DW-1:0] xs, output logic [DW-1:0] y,
                         output logic [IW-1:0] rid, output logic par);
    bit ok;
    xs = '0; y = '0; rid = '0; par = 1'b0;
    @(posedge clk); #1;
    opa[id] = a;
    opb[id] = b;
    req_valid[id] = 1'b1;
    resp_ready = (hold == 0);
    wait_grant(id, ok);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (!ok) begin
      resp_ready = 1'b1;
      return;
    end
    for (int n = 0; n < NIB; n++) begin
      @(negedge clk);
      xs = {xs[DW-5:0], xor_a};
    end
    @(negedge clk);
    chk("latency_resp_valid", resp_valid, 1'b1);
    y = resp_y;
    rid = resp_id;
`ifdef XOR86_SCHED_PARITY_EN
    par = resp_par;
`endif
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("bp_resp_valid", resp_valid, 1'b1);
        chk("bp_resp_y", resp_y, y);
        chk("bp_resp_id", resp_id, rid);
        chk("bp_req_ready", req_ready, '0);
        chk("bp_busy", busy, 1'b1);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_still_done", resp_valid, 1'b1);
    end
    @(negedge clk);
    chk("idle_after_resp", busy, 1'b0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [DW-1:0] xs, y;
    logic [IW-1:0] rid;
    logic par;
    bit ok;
    int gl[$];

    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = DW'(16'h1111 * (i + 1));
      opb[i] = DW'(16'h0F0F + i);
    end

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_y", resp_y, 16'h0);
    chk("rst_resp_id", resp_id, 2'd0);

    // Idle drive for 10 cycles
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_xor_a", xor_a, 4'h0);
      chk("idle_xor_b", xor_b, 4'h0);
      chk("idle_req_ready", req_ready, 4'h0);
      chk("idle_busy", busy, 1'b0);
    end

    // Single job from requester 1
    run_job(2'd1, 16'hA5F0, 16'h0FF0, 0, xs, y, rid, par);
    chk("t1_xor_a_seq", xs, 16'h0F5A);
    chk("t1_resp_y", y, 16'hAA00);
    chk("t1_resp_id", rid, 2'd1);

    // Backpressure on requester 2
    run_job(2'd2, 16'h1234, 16'hFFFF, 3, xs, y, rid, par);
    chk("t3_resp_y", y, 16'hEDCB);
    chk("t3_resp_id", rid, 2'd2);

    // All requesters valid from reset: fair rotation
    do_reset();
    @(posedge clk); #1;
    req_valid = '1;
    resp_ready = 1'b1;
    for (int n = 0; n < 80 && gl.size() < 5; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gl.push_back(i);
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("t2_grant_count", gl.size(), 5);
    while (gl.size() < 5) gl.push_back(-1);
    chk("t2_grant0", gl[0], 0);
    chk("t2_grant1", gl[1], 1);
    chk("t2_grant2", gl[2], 2);
    chk("t2_grant3", gl[3], 3);
    chk("t2_grant4", gl[4], 0);
    wait_idle("t2_drain");

    // Reset mid-RUN while the third nibble is on the bus
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    wait_grant(2'd1, ok);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_pre_rst_busy", busy, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_busy", busy, 1'b0);
    chk("t4_resp_valid", resp_valid, 1'b0);
    chk("t4_resp_y", resp_y, 16'h0);
    chk("t4_resp_id", resp_id, 2'd0);
    chk("t4_xor_a", xor_a, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'b1001;
    wait_grant(2'd0, ok);
    chk("t4_first_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle("t4_drain");

`ifdef XOR86_SCHED_PARITY_EN
    run_job(2'd3, 16'h0001, 16'h0000, 0, xs, y, rid, par);
    chk("par_one", par, 1'b1);
    run_job(2'd0, 16'h0003, 16'h0000, 0, xs, y, rid, par);
    chk("par_zero", par, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor86_sched.md
# xor86_sched

Time-shared sequencer for a single 4-bit 74x86 quad-XOR resource. Up to NREQ requesters submit DW-bit XOR jobs over valid/ready. A round-robin arbiter grants one job at a time, streams its operands through the shared 74x86 one nibble per cycle (LSB nibble first), and returns the assembled result with the requester ID. It sits between bus-side requesters and the mapped XOR gate package, so a single chip serves every XOR in the design.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DW, 16: operand width; multiple of 4, at least 4; NIB = DW/4.
- IW, derived: max(1, clog2(NREQ)).

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester job valid
- req_ready  out  NREQ  per-requester accept strobe (one-hot or zero)
- req_a  in  NREQ*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing
- xor_a  out  4  nibble to 74x86 A inputs
- xor_b  out  4  nibble to 74x86 B inputs
- xor_y  in  4  74x86 Y outputs (combinational from xor_a/xor_b)
- resp_valid  out  1  result available
- resp_ready  in  1  result consumed
- resp_id  out  IW  index of the granted requester
- resp_y  out  DW  A^B result
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if any req_valid, pick first valid index searching ptr+1, ptr+2, … mod NREQ. Assert req_ready[i] combinationally that cycle. At the edge, latch req_a/req_b, set id=i, ptr=i, cnt=0, go to RUN. If no valid, stay in IDLE.
- RUN: xor_a/xor_b = latched A/B nibble[cnt]. Each edge writes xor_y into resp_y nibble[cnt] and increments cnt. When cnt==NIB-1, go to DONE.
- DONE: resp_valid=1. resp_id and resp_y are held stable. On resp_valid&resp_ready, go to IDLE.
- req_ready is 0 outside IDLE. Jobs are never accepted during RUN or DONE.
- xor_a/xor_b are 4'h0 outside RUN.
- Reset values: state IDLE, ptr=NREQ-1 (requester 0 wins first), cnt=0, resp_y=0, resp_id=0, resp_valid=0, req_ready=0, xor_a=xor_b=0, busy=0.
- A requester dropping req_valid while not granted is legal, and nothing is latched for it.
- Reset asserted mid-RUN or mid-DONE abandons the job. No response is produced. State returns to reset values on that edge.

## Timing
- Accept edge T (req_valid[i]&req_ready[i] sampled high).
- RUN occupies cycles T+1 .. T+NIB.
- resp_valid rises at T+NIB+1. Latency is NIB+1 cycles.
- Response handshake at edge R puts IDLE at R+1. The earliest next accept is edge R+1.
- Best-case throughput: one job per NIB+2 cycles.
- The xor_y path is combinational through the external package. The full cycle is available for the 74x86 propagation delay.
- Fairness: with all NREQ valid continuously, each requester is granted exactly once per NREQ jobs.

## Configuration
- XOR86_SCHED_PARITY_EN defined: adds output resp_par (1 bit).
  - resp_par is computed as reduction-XOR of resp_y, updated with resp_y and valid with resp_valid.
  - Reset value is 0.
- XOR86_SCHED_PARITY_EN undefined: no resp_par port and no parity logic. All other behaviour is identical.

## Test plan
- Single job, NREQ=4, DW=16: req 1 with A=16'hA5F0, B=16'h0FF0, resp_ready=1.
  - xor_a sequence is 0,F,5,A.
  - resp_valid is high at T+5 with resp_y=16'hAA00, resp_id=1.
- All four req_valid held high from reset: grant order is 0,1,2,3,0.
  - Each req_ready is a one-cycle pulse, one per job.
- Backpressure: hold resp_ready=0 for 3 cycles in DONE.
  - resp_valid, resp_y and resp_id stay stable.
  - req_ready stays 0 and busy=1.
  - IDLE begins the cycle after resp_ready rises.
- Reset mid-RUN: pull rst_n low while cnt=2.
  - The next cycle shows all outputs at reset values and no resp_valid.
  - Then req 0 and req 3 both valid: req 0 is granted first.
- Idle drive: no requests for 10 cycles.
  - xor_a=xor_b=0, req_ready=0, busy=0 throughout.
- With XOR86_SCHED_PARITY_EN: A=16'h0001, B=16'h0000 gives resp_par=1.
  - A=16'h0003, B=16'h0000 gives resp_par=0.
